// File: rtl/mips_memory3_if.sv
// Request/response bus of the MIPS instruction/data memory.
// The master issues requests and supplies write data; the slave (the
// memory) returns read data, the beat address, busy and error.
interface mips_memory3_if;
    logic        enable;
    logic        rw;
    logic [31:0] addr;
    logic [2:0]  access_size;
    logic        sign_ext;
    logic [31:0] din;
    logic        busy;
    logic [31:0] dout;
    logic        dout_valid;
    logic [31:0] pc;
    logic        error;

    modport master (
        output enable, rw, addr, access_size, sign_ext, din,
        input  busy, dout, dout_valid, pc, error
    );

    modport slave (
        input  enable, rw, addr, access_size, sign_ext, din,
        output busy, dout, dout_valid, pc, error
    );
endinterface

// File: rtl/mips_memory3.sv
// Byte-addressed, big-endian instruction/data memory for the MIPS pipeline.
// Serves single word/half/byte accesses and 4/8/16-word bursts. Beat k of a
// request accepted at edge T executes at edge T+1+k; a new request may be
// accepted on the last beat of the current one, so bursts chain without a
// bubble. Out-of-range, misaligned or illegal requests get a one-cycle error.
module mips_memory3 #(
    parameter int          MEMSIZE    = 1024,
    parameter logic [31:0] START_ADDR = 32'h8002_0000,
    parameter int          MAX_BURST  = 16
) (
    input  logic           clk,
    input  logic           rst,
    mips_memory3_if.slave  bus
);
    localparam int AW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

    typedef enum logic {IDLE, BURST} state_t;
    typedef enum logic [1:0] {KIND_WORD, KIND_HALF, KIND_BYTE} kind_t;

    state_t          state, state_next;
    logic [4:0]      beats_rem, beats_next;

    logic [AW-1:0]   cur_off;
    logic            cur_rw;
    kind_t           cur_kind;
    logic            cur_sign;
    logic [31:0]     din_q;
    logic            err_pend;

    logic [4:0]      req_beats;
    kind_t           req_kind;
    logic            req_illegal;
    logic [32:0]     req_bytes;
    logic [31:0]     req_off;
    logic            req_bad;

    logic            can_accept, take, reject, beat_en;
    logic [AW-1:0]   a1, a2, a3;
    logic [31:0]     rd_data;

    logic [7:0]      mem [MEMSIZE];

    // Decode the request on the bus: beat count, access kind and legality.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        req_beats   = 5'd1;
        req_kind    = KIND_WORD;
        req_illegal = 1'b0;
        case (bus.access_size)
            3'b000:  req_beats = 5'd1;
            3'b001:  req_beats = 5'd4;
            3'b010:  req_beats = 5'd8;
            3'b011:  req_beats = 5'd16;
            3'b100:  req_kind  = KIND_BYTE;
            3'b101:  req_kind  = KIND_HALF;
            default: req_illegal = 1'b1;
        endcase
        case (req_kind)
            KIND_HALF: req_bytes = 33'd2;
            KIND_BYTE: req_bytes = 33'd1;
            default:   req_bytes = {26'd0, req_beats, 2'b00};
        endcase
        req_off = bus.addr - START_ADDR;
        req_bad = req_illegal
                | (bus.addr < START_ADDR)
                | (({1'b0, req_off} + req_bytes) > 33'(MEMSIZE))
                | ((req_kind == KIND_WORD) && (bus.addr[1:0] != 2'b00))
                | ((req_kind == KIND_HALF) && bus.addr[0])
                | (int'(req_beats) > MAX_BURST);
    end

    assign can_accept = (state == IDLE) || (beats_rem == 5'd1);
    assign take       = bus.enable && can_accept && !req_bad;
    assign reject     = bus.enable && can_accept && req_bad;
    assign beat_en    = (state == BURST);
    assign bus.busy   = (beats_rem > 5'd1);

    // Next state: count beats down, chain a new request on the last beat.
    always_comb begin
        state_next = state;
        beats_next = beats_rem;
        if (state == BURST) begin
            if (beats_rem == 5'd1) begin
                state_next = IDLE;
                beats_next = 5'd0;
            end else begin
                beats_next = beats_rem - 5'd1;
            end
        end
        if (take) begin
            state_next = BURST;
            beats_next = req_beats;
        end else if (reject) begin
            state_next = IDLE;
            beats_next = 5'd0;
        end
    end

    // FSM state and remaining-beat counter.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beats_rem <= 5'd0;
        end else begin
            state     <= state_next;
            beats_rem <= beats_next;
        end
    end

    assign a1 = cur_off + AW'(1);
    assign a2 = cur_off + AW'(2);
    assign a3 = cur_off + AW'(3);

    // Assemble big-endian read data for the current beat, with extension.
    always_comb begin
        rd_data = '0;
        case (cur_kind)
            KIND_WORD: rd_data = {mem[cur_off], mem[a1], mem[a2], mem[a3]};
            KIND_HALF: rd_data = {{16{cur_sign & mem[cur_off][7]}}, mem[cur_off], mem[a1]};
            KIND_BYTE: rd_data = {{24{cur_sign & mem[cur_off][7]}}, mem[cur_off]};
            default:   rd_data = '0;
        endcase
    end

    // Request capture, beat address stepping, read outputs and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_off        <= '0;
            cur_rw         <= 1'b0;
            cur_kind       <= KIND_WORD;
            cur_sign       <= 1'b0;
            din_q          <= '0;
            err_pend       <= 1'b0;
            bus.error      <= 1'b0;
            bus.dout       <= '0;
            bus.pc         <= '0;
            bus.dout_valid <= 1'b0;
        end else begin
            // Write beat k consumes the din that was present one edge earlier.
            din_q          <= bus.din;
            err_pend       <= reject;
            bus.error      <= err_pend;
            bus.dout_valid <= 1'b0;
            if (beat_en && !cur_rw) begin
                bus.dout       <= rd_data;
                bus.pc         <= START_ADDR + 32'(cur_off);
                bus.dout_valid <= 1'b1;
            end
            if (take) begin
                cur_off  <= req_off[AW-1:0];
                cur_rw   <= bus.rw;
                cur_kind <= req_kind;
                cur_sign <= bus.sign_ext;
            end else if (beat_en) begin
                cur_off  <= cur_off + AW'(4);
            end
        end
    end

    // Write beats into the byte array in big-endian order.
    // NOTE: the storage array has no reset; contents survive rst and only the control path is cleared.
    always_ff @(posedge clk) begin
        if (beat_en && cur_rw) begin
            case (cur_kind)
                KIND_WORD: begin
                    mem[cur_off] <= din_q[31:24];
                    mem[a1]      <= din_q[23:16];
                    mem[a2]      <= din_q[15:8];
                    mem[a3]      <= din_q[7:0];
                end
                KIND_HALF: begin
                    mem[cur_off] <= din_q[15:8];
                    mem[a1]      <= din_q[7:0];
                end
                KIND_BYTE: mem[cur_off] <= din_q[7:0];
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_memory3.sv
// Directed self-checking bench for mips_memory3: single and burst accesses,
// byte/half extension, error responses, back-to-back chaining and reset
// during a burst write.
module tb_mips_memory3;
    localparam logic [31:0] BASE = 32'h8002_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   busy_cnt;

    mips_memory3_if bus ();

    mips_memory3 #(
        .MEMSIZE   (1024),
        .START_ADDR(BASE),
        .MAX_BURST (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write n consecutive values first, first+1, ... as one request.
    task automatic burst_write(input logic [31:0] addr, input logic [2:0] size,
                               input int n, input logic [31:0] first);
        bus.enable      = 1'b1;
        bus.rw          = 1'b1;
        bus.addr        = addr;
        bus.access_size = size;
        bus.sign_ext    = 1'b0;
        bus.din         = first;
        tick();
        bus.enable = 1'b0;
        for (int k = 1; k <= n; k++) begin
            bus.din = first + 32'(k);
            tick();
        end
        check("wr_no_valid", bus.dout_valid, 1'b0);
    endtask

    // Read n beats; expect first+k on beat k at addr+4k. Counts busy samples.
    task automatic read_seq(input string tag, input logic [31:0] addr, input logic [2:0] size,
                            input logic sign, input int n, input logic [31:0] first,
                            output int bcnt);
        bus.enable      = 1'b1;
        bus.rw          = 1'b0;
        bus.addr        = addr;
        bus.access_size = size;
        bus.sign_ext    = sign;
        tick();
        bus.enable = 1'b0;
        bcnt = int'(bus.busy);
        check({tag, "_acc_valid"}, bus.dout_valid, 1'b0);
        for (int k = 0; k < n; k++) begin
            tick();
            bcnt += int'(bus.busy);
            check({tag, "_valid"}, bus.dout_valid, 1'b1);
            check({tag, "_dout"}, bus.dout, first + 32'(k));
            check({tag, "_pc"}, bus.pc, addr + 32'(4 * k));
        end
        tick();
        bcnt += int'(bus.busy);
        check({tag, "_valid_end"}, bus.dout_valid, 1'b0);
    endtask

    // Issue a request that must be rejected with a single error pulse.
    task automatic err_case(input string tag, input logic rw, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] data);
        bus.enable      = 1'b1;
        bus.rw          = rw;
        bus.addr        = addr;
        bus.access_size = size;
        bus.sign_ext    = 1'b0;
        bus.din         = data;
        tick();
        bus.enable = 1'b0;
        check({tag, "_err_t0"}, bus.error, 1'b0);
        check({tag, "_busy_t0"}, bus.busy, 1'b0);
        tick();
        check({tag, "_err_t1"}, bus.error, 1'b1);
        check({tag, "_valid_t1"}, bus.dout_valid, 1'b0);
        check({tag, "_busy_t1"}, bus.busy, 1'b0);
        tick();
        check({tag, "_err_t2"}, bus.error, 1'b0);
        check({tag, "_valid_t2"}, bus.dout_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable      = 1'b0;
        bus.rw          = 1'b0;
        bus.addr        = '0;
        bus.access_size = '0;
        bus.sign_ext    = 1'b0;
        bus.din         = '0;

        // Reset state
        tick();
        tick();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_dout", bus.dout, 32'h0);
        check("rst_valid", bus.dout_valid, 1'b0);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_error", bus.error, 1'b0);
        rst = 1'b0;
        tick();

        // Single word write and readback
        burst_write(BASE + 32'h10, 3'b000, 1, 32'hDEAD_BEEF);
        read_seq("word", BASE + 32'h10, 3'b000, 1'b0, 1, 32'hDEAD_BEEF, busy_cnt);
        check("word_busy", 32'(busy_cnt), 32'd0);

        // 4-word burst write and read
        burst_write(BASE, 3'b001, 4, 32'd1);
        read_seq("b4", BASE, 3'b001, 1'b0, 4, 32'd1, busy_cnt);
        check("b4_busy_cycles", 32'(busy_cnt), 32'd3);

        // Byte / halfword with and without sign extension
        burst_write(BASE + 32'h20, 3'b000, 1, 32'h1122_3344);
        burst_write(BASE + 32'h21, 3'b100, 1, 32'h0000_0080);
        read_seq("byte_sx", BASE + 32'h21, 3'b100, 1'b1, 1, 32'hFFFF_FF80, busy_cnt);
        read_seq("byte_zx", BASE + 32'h21, 3'b100, 1'b0, 1, 32'h0000_0080, busy_cnt);
        burst_write(BASE + 32'h22, 3'b101, 1, 32'h0000_8001);
        read_seq("half_sx", BASE + 32'h22, 3'b101, 1'b1, 1, 32'hFFFF_8001, busy_cnt);
        read_seq("half_zx", BASE + 32'h22, 3'b101, 1'b0, 1, 32'h0000_8001, busy_cnt);
        read_seq("mixed_word", BASE + 32'h20, 3'b000, 1'b0, 1, 32'h1180_8001, busy_cnt);

        // Rejected requests leave memory untouched
        burst_write(BASE + 32'h3E0, 3'b000, 1, 32'hCAFE_F00D);
        err_case("below", 1'b0, 32'h8001_FFFC, 3'b000, 32'h0);
        err_case("over", 1'b1, BASE + 32'h3E0, 3'b011, 32'h0BAD_0BAD);
        read_seq("over_rb", BASE + 32'h3E0, 3'b000, 1'b0, 1, 32'hCAFE_F00D, busy_cnt);
        err_case("misalign", 1'b1, BASE + 32'h2, 3'b000, 32'hFFFF_FFFF);
        read_seq("misalign_rb", BASE, 3'b000, 1'b0, 1, 32'd1, busy_cnt);
        err_case("illegal", 1'b1, BASE + 32'h10, 3'b111, 32'h0);
        read_seq("illegal_rb", BASE + 32'h10, 3'b000, 1'b0, 1, 32'hDEAD_BEEF, busy_cnt);

        // Back-to-back: enable during busy ignored, chained on the last beat
        burst_write(BASE + 32'h40, 3'b010, 8, 32'h100);
        bus.enable      = 1'b1;
        bus.rw          = 1'b0;
        bus.addr        = BASE + 32'h40;
        bus.access_size = 3'b010;
        bus.sign_ext    = 1'b0;
        tick();
        bus.addr        = BASE;
        bus.access_size = 3'b000;
        check("b2b_busy_t0", bus.busy, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("b2b_valid", bus.dout_valid, 1'b1);
            check("b2b_dout", bus.dout, 32'h100 + 32'(k));
            check("b2b_pc", bus.pc, BASE + 32'h40 + 32'(4 * k));
            if (k == 6) begin
                check("b2b_busy_last", bus.busy, 1'b0);
                bus.addr = BASE + 32'h10;
            end
            if (k == 7) bus.enable = 1'b0;
        end
        tick();
        check("b2b_next_valid", bus.dout_valid, 1'b1);
        check("b2b_next_dout", bus.dout, 32'hDEAD_BEEF);
        check("b2b_next_pc", bus.pc, BASE + 32'h10);
        tick();
        check("b2b_end_valid", bus.dout_valid, 1'b0);

        // Reset during a 4-word burst write after two beats
        burst_write(BASE + 32'h80, 3'b001, 4, 32'hA0);
        bus.enable      = 1'b1;
        bus.rw          = 1'b1;
        bus.addr        = BASE + 32'h80;
        bus.access_size = 3'b001;
        bus.din         = 32'hB0;
        tick();
        bus.enable = 1'b0;
        bus.din    = 32'hB1;
        tick();
        bus.din    = 32'hB2;
        tick();
        bus.din    = 32'hB3;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_dout", bus.dout, 32'h0);
        check("mid_rst_valid", bus.dout_valid, 1'b0);
        check("mid_rst_pc", bus.pc, 32'h0);
        check("mid_rst_error", bus.error, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        read_seq("rst_rb0", BASE + 32'h80, 3'b000, 1'b0, 1, 32'hB0, busy_cnt);
        read_seq("rst_rb1", BASE + 32'h84, 3'b000, 1'b0, 1, 32'hB1, busy_cnt);
        read_seq("rst_rb2", BASE + 32'h88, 3'b000, 1'b0, 1, 32'hA2, busy_cnt);
        read_seq("rst_rb3", BASE + 32'h8C, 3'b000, 1'b0, 1, 32'hA3, busy_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_memory3.md
Name: mips_memory3

Overview:
- Parametrised, byte-addressed, big-endian instruction/data memory for the MIPS fetch-decode pipeline.
- Serves single and burst (4/8/16-word) reads and writes, plus byte and halfword accesses with optional sign extension.
- Adds reset, a read-valid strobe, and an error response for out-of-range or misaligned requests.
- Used as I-memory (burst fetch) and D-memory (byte/half/word load-store).

Parameters:
MEMSIZE, 1024, memory size in bytes; storage is MEMSIZE bytes at offsets 0..MEMSIZE-1
START_ADDR, 32'h8002_0000, physical address of byte offset 0
MAX_BURST, 16, largest legal burst in words; access_size codes needing more beats are rejected with error

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  request strobe; sampled on clk when request can be accepted
rw  input  1  1 = write, 0 = read; sampled with request
addr  input  32  physical start address; sampled with request
access_size  input  3  000 word, 001 4 words, 010 8 words, 011 16 words, 100 byte, 101 halfword; others illegal
sign_ext  input  1  byte/half reads: 1 = sign-extend, 0 = zero-extend; sampled with request
din  input  32  write data; a new word is consumed every beat
busy  output  1  high while more than one beat of the current burst remains
dout  output  32  read data, big-endian
dout_valid  output  1  one cycle per read beat; qualifies dout and pc
pc  output  32  physical address of the beat currently on dout
error  output  1  one-cycle pulse for a rejected request

Behaviour:
- Reset (async): busy=0, dout=0, dout_valid=0, pc=0, error=0; FSM to IDLE; beat counter 0. Memory contents are not reset.
- Reset mid-burst aborts the remaining beats. Writes completed before reset persist.
- FSM states: IDLE and BURST.
- A request is accepted at an edge where enable=1 and either the FSM is in IDLE or the current beat is the last one (back-to-back, no bubble).
- Beats N: 1 for word/byte/half; 4, 8 or 16 for burst codes.
- Request accepted at edge T: beat k (k = 0..N-1) executes at edge T+1+k.
- Read beat: dout, pc and dout_valid update at that edge.
- Write beat: writes din as sampled at edge T+k. Beat 0 uses the din present with the request.
- Beat address = offset + 4k for bursts, where offset = addr - START_ADDR, computed in 32-bit unsigned arithmetic. Offsets never wrap.
- Word: mem[a] -> dout[31:24] ... mem[a+3] -> dout[7:0]. Writes use the same byte order.
- Halfword: mem[a] -> dout[15:8], mem[a+1] -> dout[7:0]. Upper 16 bits are copies of dout[15] if sign_ext, else 0. Writes store din[15:0].
- Byte: mem[a] -> dout[7:0]. Upper 24 bits are copies of bit 7 if sign_ext, else 0. Writes store din[7:0].
- Rejection conditions, checked at acceptance:
  - addr < START_ADDR;
  - offset + bytes > MEMSIZE, where bytes = 4N, 2 or 1;
  - word or burst with addr[1:0] != 0;
  - halfword with addr[0] != 0;
  - illegal access_size;
  - burst N > MAX_BURST.
- On rejection: error=1 at edge T+1 for exactly one cycle. No memory access, dout_valid stays 0, busy stays 0, FSM returns to or stays in IDLE.
- busy = 1 while beats remaining after the current edge is greater than 1. It is never asserted for single-beat requests.
- enable while busy=1 is ignored; no queueing.
- dout and pc hold their last value when dout_valid=0.
- dout_valid=0 on every write beat.
- Read during write to the same address cannot occur within one request. Across a back-to-back pair, the read sees the completed write.

Test Plan:
- Reset, then write word 32'hDEADBEEF at 32'h8002_0010, then read word -> dout=32'hDEADBEEF, pc=32'h8002_0010, dout_valid high exactly 1 cycle, 1 cycle after acceptance.
- 4-word burst write of 1,2,3,4 starting at 32'h8002_0000, then 4-word burst read -> busy high 3 cycles; dout 1,2,3,4 on consecutive cycles; pc 0x..00/04/08/0C.
- Byte 8'h80 at 32'h8002_0021: read with sign_ext=1 -> 32'hFFFF_FF80; sign_ext=0 -> 32'h0000_0080. Half 16'h8001 at 0x..22 with sign_ext=1 -> 32'hFFFF_8001.
- Errors -> each gives a 1-cycle error pulse and no dout_valid; memory remains unchanged on readback:
  - word read at 32'h8001_FFFC;
  - 16-word burst at START_ADDR+MEMSIZE-32;
  - word at 32'h8002_0002;
  - access_size 3'b111.
- Back-to-back: a new enable on the last beat of an 8-word read -> the next request's first beat follows with no idle cycle; enable during busy is ignored.
- Assert rst after beat 2 of a 4-word burst write -> all outputs 0 immediately; readback shows beats 0-1 written and beats 2-3 unchanged.
